// File: rtl/bus_dma_host.sv
// Word-copy DMA engine: device port for SRC/DST/LEN/CTRL registers and a host port
// that copies LEN full words from SRC to DST, one bus transaction in flight at a time.
module bus_dma_host #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dev_req_i,
  input  logic                 dev_we_i,
  input  logic [3:0]           dev_be_i,
  input  logic [AddrWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0] dev_wdata_i,
  output logic                 dev_rvalid_o,
  output logic [DataWidth-1:0] dev_rdata_o,
  output logic                 dev_err_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  output logic                 host_we_o,
  output logic [3:0]           host_be_o,
  output logic [DataWidth-1:0] host_wdata_o,
  input  logic                 host_rvalid_i,
  input  logic [DataWidth-1:0] host_rdata_i,
  input  logic                 host_err_i,
  output logic                 irq_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;
  localparam logic [2:0] FINISH  = 3'd5;

  localparam logic [1:0] REG_SRC = 2'd0;
  localparam logic [1:0] REG_DST = 2'd1;
  localparam logic [1:0] REG_LEN = 2'd2;

  localparam logic [AddrWidth-1:0] WORD_STEP = AddrWidth'(4);
  localparam logic [AddrWidth-1:0] WORD_MASK = ~AddrWidth'(3);

  logic [2:0]           state_q, state_d;
  logic [AddrWidth-1:0] src_q, src_d;
  logic [AddrWidth-1:0] dst_q, dst_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 ie_q, ie_d;
  logic                 err_pend_q, err_pend_d;

  logic                 dev_rvalid_q, dev_rvalid_d;
  logic [DataWidth-1:0] dev_rdata_q, dev_rdata_d;
  logic                 dev_err_q, dev_err_d;
  logic                 host_req_q, host_req_d;
  logic [AddrWidth-1:0] host_addr_q, host_addr_d;
  logic                 host_we_q, host_we_d;
  logic [3:0]           host_be_q, host_be_d;
  logic [DataWidth-1:0] host_wdata_q, host_wdata_d;
  logic                 irq_q, irq_d;

  logic                 busy;
  logic                 wr_ok;
  logic [1:0]           reg_sel;
  logic [DataWidth-1:0] rd_val;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{dev_addr_i[AddrWidth-1:4], dev_addr_i[1:0]};

  // Register writes, copy sequencing and next values of every registered output
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    data_d     = data_q;
    done_d     = done_q;
    err_d      = err_q;
    ie_d       = ie_q;
    err_pend_d = err_pend_q;
    busy       = (state_q != IDLE);
    wr_ok      = dev_req_i && dev_we_i && (dev_be_i == 4'hF);
    reg_sel    = dev_addr_i[3:2];

    if (wr_ok) begin
      case (reg_sel)
        REG_SRC: if (!busy) src_d = AddrWidth'(dev_wdata_i) & WORD_MASK;
        REG_DST: if (!busy) dst_d = AddrWidth'(dev_wdata_i) & WORD_MASK;
        REG_LEN: if (!busy) len_d = dev_wdata_i[LenWidth-1:0];
        default: begin
          ie_d = dev_wdata_i[3];
          if (dev_wdata_i[1]) done_d = 1'b0;
          if (dev_wdata_i[2]) err_d = 1'b0;
          if (dev_wdata_i[0] && !busy) begin
            if (len_q == '0) begin
              done_d = 1'b1;
            end else begin
              state_d    = RD_REQ;
              err_pend_d = 1'b0;
            end
          end
        end
      endcase
    end

    // Hardware status updates come after software clears so a same-cycle set wins
    case (state_q)
      IDLE: begin end
      RD_REQ: if (host_gnt_i) state_d = RD_WAIT;
      RD_WAIT: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            err_pend_d = 1'b1;
            state_d    = FINISH;
          end else begin
            data_d  = host_rdata_i;
            state_d = WR_REQ;
          end
        end
      end
      WR_REQ: if (host_gnt_i) state_d = WR_WAIT;
      WR_WAIT: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            err_pend_d = 1'b1;
            state_d    = FINISH;
          end else begin
            src_d   = src_q + WORD_STEP;
            dst_d   = dst_q + WORD_STEP;
            len_d   = len_q - LenWidth'(1);
            state_d = (len_q == LenWidth'(1)) ? FINISH : RD_REQ;
          end
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        if (err_pend_q) err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (reg_sel)
      REG_SRC: rd_val = DataWidth'(src_q);
      REG_DST: rd_val = DataWidth'(dst_q);
      REG_LEN: rd_val = DataWidth'(len_q);
      default: rd_val = DataWidth'({ie_q, err_q, done_q, busy});
    endcase

    dev_rvalid_d = dev_req_i;
    dev_rdata_d  = (dev_req_i && !dev_we_i) ? rd_val : '0;
    dev_err_d    = dev_req_i && dev_we_i && (dev_be_i != 4'hF);

    // Host outputs follow the next state so they are stable for the whole request phase
    host_req_d   = (state_d == RD_REQ) || (state_d == WR_REQ);
    host_we_d    = (state_d == WR_REQ);
    host_addr_d  = host_we_d ? dst_d : (host_req_d ? src_d : '0);
    host_be_d    = host_req_d ? 4'hF : 4'h0;
    host_wdata_d = host_we_d ? data_d : '0;
    irq_d        = done_d & ie_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      data_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ie_q         <= 1'b0;
      err_pend_q   <= 1'b0;
      dev_rvalid_q <= 1'b0;
      dev_rdata_q  <= '0;
      dev_err_q    <= 1'b0;
      host_req_q   <= 1'b0;
      host_addr_q  <= '0;
      host_we_q    <= 1'b0;
      host_be_q    <= 4'h0;
      host_wdata_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      data_q       <= data_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ie_q         <= ie_d;
      err_pend_q   <= err_pend_d;
      dev_rvalid_q <= dev_rvalid_d;
      dev_rdata_q  <= dev_rdata_d;
      dev_err_q    <= dev_err_d;
      host_req_q   <= host_req_d;
      host_addr_q  <= host_addr_d;
      host_we_q    <= host_we_d;
      host_be_q    <= host_be_d;
      host_wdata_q <= host_wdata_d;
      irq_q        <= irq_d;
    end
  end

  assign dev_rvalid_o = dev_rvalid_q;
  assign dev_rdata_o  = dev_rdata_q;
  assign dev_err_o    = dev_err_q;
  assign host_req_o   = host_req_q;
  assign host_addr_o  = host_addr_q;
  assign host_we_o    = host_we_q;
  assign host_be_o    = host_be_q;
  assign host_wdata_o = host_wdata_q;
  assign irq_o        = irq_q;

endmodule
